// File: rtl/cavlc_pkg.sv
// Shared CAVLC total_zeros constants: codeword tables common with the encoder side.
// Entries are {code[2:0], len[3:0]}; in hex the high digit is the code value, the low digit the length.
package cavlc_pkg;

  localparam int unsigned TZ_WIN_W   = 9;
  localparam int unsigned TZ_ENTRY_W = 7;
  localparam int unsigned TZ_ROWS    = 18;
  localparam int unsigned TZ_COLS    = 16;
  localparam int unsigned TZ_ROW_W   = 5;
  localparam int unsigned TC_W       = 5;
  localparam int unsigned TC_MAX_4X4 = 15;
  localparam int unsigned TC_MAX_CDC = 3;
  localparam int unsigned CDC_ROW0   = 15;

  typedef logic [TZ_ENTRY_W-1:0] tz_entry_t;

  typedef struct packed {
    logic       err;
    logic [3:0] tz;
    logic [3:0] len;
  } tz_res_t;

  // Rows 0..14: 4x4 blocks with TotalCoeff 1..15; rows 15..17: chroma DC with TotalCoeff 1..3.
  localparam tz_entry_t TZ_TAB [TZ_ROWS][TZ_COLS] = '{
    '{7'h11, 7'h33, 7'h23, 7'h34, 7'h24, 7'h35, 7'h25, 7'h36,
      7'h26, 7'h37, 7'h27, 7'h38, 7'h28, 7'h39, 7'h29, 7'h19},
    '{7'h73, 7'h63, 7'h53, 7'h43, 7'h33, 7'h54, 7'h44, 7'h34,
      7'h24, 7'h35, 7'h25, 7'h36, 7'h26, 7'h16, 7'h06, 7'h00},
    '{7'h54, 7'h73, 7'h63, 7'h53, 7'h44, 7'h34, 7'h43, 7'h33,
      7'h24, 7'h35, 7'h25, 7'h16, 7'h15, 7'h06, 7'h00, 7'h00},
    '{7'h35, 7'h73, 7'h54, 7'h44, 7'h63, 7'h53, 7'h43, 7'h34,
      7'h33, 7'h24, 7'h25, 7'h15, 7'h05, 7'h00, 7'h00, 7'h00},
    '{7'h54, 7'h44, 7'h34, 7'h73, 7'h63, 7'h53, 7'h43, 7'h33,
      7'h24, 7'h15, 7'h14, 7'h05, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h16, 7'h15, 7'h73, 7'h63, 7'h53, 7'h43, 7'h33, 7'h23,
      7'h14, 7'h13, 7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h16, 7'h15, 7'h53, 7'h43, 7'h33, 7'h32, 7'h23, 7'h14,
      7'h13, 7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h16, 7'h14, 7'h15, 7'h33, 7'h32, 7'h22, 7'h23, 7'h13,
      7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h16, 7'h06, 7'h14, 7'h32, 7'h22, 7'h13, 7'h12, 7'h15,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h15, 7'h05, 7'h13, 7'h32, 7'h22, 7'h12, 7'h14, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h04, 7'h14, 7'h13, 7'h23, 7'h11, 7'h33, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h04, 7'h14, 7'h12, 7'h11, 7'h13, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h03, 7'h13, 7'h11, 7'h12, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h02, 7'h12, 7'h11, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h01, 7'h11, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h11, 7'h12, 7'h13, 7'h03, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h11, 7'h12, 7'h02, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
    '{7'h11, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}
  };

  function automatic logic [2:0] tz_code(input tz_entry_t e);
    return e[6:4];
  endfunction

  function automatic logic [3:0] tz_len(input tz_entry_t e);
    return e[3:0];
  endfunction

  function automatic logic tz_tc_legal(input logic [TC_W-1:0] tc, input logic cdc);
    if (cdc) return (tc != '0) && (tc <= TC_W'(TC_MAX_CDC));
    return (tc != '0) && (tc <= TC_W'(TC_MAX_4X4));
  endfunction

  // Illegal TotalCoeff maps to row 0; the legality flag gates matching.
  function automatic logic [TZ_ROW_W-1:0] tz_row_idx(input logic [TC_W-1:0] tc, input logic cdc);
    if (!tz_tc_legal(tc, cdc)) return '0;
    if (cdc) return TZ_ROW_W'(CDC_ROW0) + TZ_ROW_W'(tc) - TZ_ROW_W'(1);
    return TZ_ROW_W'(tc) - TZ_ROW_W'(1);
  endfunction

endpackage

// File: rtl/cavlc_tz_row_match.sv
// Combinational total_zeros matcher: selects a table row and compares every codeword
// against the head of the bitstream window in parallel.
module cavlc_tz_row_match
  import cavlc_pkg::*;
(
  input  logic [TZ_ROW_W-1:0] row_idx,
  input  logic                row_ok,
  input  logic [TZ_WIN_W-1:0] bits,
  output tz_res_t             res_c
);

  logic [TZ_COLS-1:0] hit;

  // Tables are prefix-free, so at most one hit is set and OR-reduction yields its index.
  always_comb begin
    tz_entry_t e;
    logic [3:0] l;
    hit   = '0;
    res_c = '0;
    e     = '0;
    l     = '0;
    for (int unsigned k = 0; k < TZ_COLS; k++) begin
      e = TZ_TAB[row_idx][k];
      l = tz_len(e);
      hit[k] = row_ok && (l != 4'd0) &&
               ((bits >> (4'(TZ_WIN_W) - l)) == TZ_WIN_W'(tz_code(e)));
      if (hit[k]) begin
        res_c.tz  = res_c.tz | 4'(k);
        res_c.len = res_c.len | l;
      end
    end
    res_c.err = ~|hit;
  end

endmodule

// File: rtl/cavlc_total_zeros_dec.sv
// CAVLC total_zeros decoder: two-stage elastic pipeline (capture, then match into the
// output register) with valid/ready on both sides.
module cavlc_total_zeros_dec
  import cavlc_pkg::*;
#(
  parameter int unsigned WIN_W  = 9,
  parameter bit          ERR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_total_coeff,
  input  logic             in_chroma_dc,
  input  logic [WIN_W-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_total_zeros,
  output logic [3:0]       out_len,
  output logic             out_err
);

  logic                s1_v;
  logic [TZ_ROW_W-1:0] s1_row;
  logic                s1_ok;
  logic [WIN_W-1:0]    s1_bits;
  logic                s2_take;
  logic                s1_take;
  tz_res_t             match_c;

  assign s2_take  = ~out_valid | out_ready;
  assign s1_take  = ~s1_v | s2_take;
  assign in_ready = s1_take;

  cavlc_tz_row_match u_match (
    .row_idx (s1_row),
    .row_ok  (s1_ok),
    .bits    (s1_bits),
    .res_c   (match_c)
  );

  // Each stage loads when the stage after it is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v            <= 1'b0;
      s1_row          <= '0;
      s1_ok           <= 1'b0;
      s1_bits         <= '0;
      out_valid       <= 1'b0;
      out_total_zeros <= '0;
      out_len         <= '0;
      out_err         <= 1'b0;
    end else begin
      if (s2_take) begin
        out_valid <= s1_v;
        if (s1_v) begin
          out_total_zeros <= match_c.tz;
          out_len         <= match_c.len;
          out_err         <= ERR_EN ? match_c.err : 1'b0;
        end
      end
      if (s1_take) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_row  <= tz_row_idx(in_total_coeff, in_chroma_dc);
          s1_ok   <= tz_tc_legal(in_total_coeff, in_chroma_dc);
          s1_bits <= in_bits;
        end
      end
    end
  end

endmodule

// File: tb/tb_cavlc_total_zeros_dec.sv
// Scoreboard bench for cavlc_total_zeros_dec: a string-table reference model predicts each
// accepted request; an independent monitor checks outputs, hold behaviour and in_ready.
module tb_cavlc_total_zeros_dec;

  typedef struct packed {
    logic       err;
    logic [3:0] tz;
    logic [3:0] len;
  } res_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_total_coeff;
  logic       in_chroma_dc;
  logic [8:0] in_bits;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_total_zeros;
  logic [3:0] out_len;
  logic       out_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  bit   bp_en       = 1'b0;
  bit   ready_force = 1'b1;
  bit   prev_stall  = 1'b0;
  res_t prev_res;
  bit   saw_block   = 1'b0;

  // Codewords per TotalCoeff row, listed in total_zeros order starting at 0.
  string luma_rows [15] = '{
    "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001",
    "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000",
    "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000",
    "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000",
    "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000",
    "000001 00001 111 110 101 100 011 010 0001 001 000000",
    "000001 00001 101 100 011 11 010 0001 001 000000",
    "000001 0001 00001 011 11 10 010 001 000000",
    "000001 000000 0001 11 10 001 01 00001",
    "00001 00000 001 11 10 01 0001",
    "0000 0001 001 010 1 011",
    "0000 0001 01 1 001",
    "000 001 1 01",
    "00 01 1",
    "0 1"
  };
  string cdc_rows [3] = '{"1 01 001 000", "1 01 00", "1 0"};

  cavlc_total_zeros_dec dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_total_coeff  (in_total_coeff),
    .in_chroma_dc    (in_chroma_dc),
    .in_bits         (in_bits),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_total_zeros (out_total_zeros),
    .out_len         (out_len),
    .out_err         (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [4:0] tc, input logic cdc, input logic [8:0] bits);
    res_t  r;
    string row;
    int    tz, pos, n, t;
    bit    ok;
    r = '{err: 1'b1, tz: 4'd0, len: 4'd0};
    t = int'(tc);
    if (t < 1 || t > (cdc ? 3 : 15)) return r;
    row = cdc ? cdc_rows[t-1] : luma_rows[t-1];
    tz  = 0;
    pos = 0;
    while (pos < row.len()) begin
      n = 0;
      while (pos + n < row.len() && row.getc(pos + n) != 8'h20) n++;
      ok = 1'b1;
      for (int i = 0; i < n; i++)
        if (bits[8-i] != (row.getc(pos + i) == 8'h31)) ok = 1'b0;
      if (ok) begin
        r.err = 1'b0;
        r.tz  = 4'(tz);
        r.len = 4'(n);
        return r;
      end
      tz++;
      pos += n + 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream readiness, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = bp_en ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: transfers seen at the falling edge complete at the following rising edge.
  always @(negedge clk) begin
    res_t got;
    got = '{err: out_err, tz: out_total_zeros, len: out_len};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(got), 32'(prev_res));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          n_checks++;
          if (got !== e) begin
            n_fail++;
            $display("FAIL result: actual err=%0d tz=%0d len=%0d required err=%0d tz=%0d len=%0d at %0t",
                     got.err, got.tz, got.len, e.err, e.tz, e.len, $time);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = got;
    end
  end

  // Present one request from just after a rising edge; return just after its accepting edge.
  task automatic send(input logic [4:0] tc, input logic cdc, input logic [8:0] bits);
    int waited = 0;
    in_valid       = 1'b1;
    in_total_coeff = tc;
    in_chroma_dc   = cdc;
    in_bits        = bits;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        #1;
        exp_q.push_back(model(tc, cdc, bits));
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_total_coeff = '0;
    in_chroma_dc   = 1'b0;
    in_bits        = '0;
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tz", 32'(out_total_zeros), 32'd0);
    chk("rst_len", 32'(out_len), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single request into an idle pipe: two-cycle latency.
    send(5'd1, 1'b0, 9'b011_000000);
    chk("lat_n1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n2", 32'(out_valid), 32'd1);
    wait_drain();

    // Directed table corners, illegal TotalCoeff and the unmatched all-zero window.
    send(5'd1, 1'b0, 9'b000000001);
    send(5'd2, 1'b0, 9'b000000111);
    send(5'd15, 1'b0, 9'b100000000);
    send(5'd1, 1'b1, {3'b001, 6'($urandom)});
    send(5'd3, 1'b1, {1'b0, 8'($urandom)});
    send(5'd0, 1'b0, 9'($urandom));
    send(5'd4, 1'b1, 9'($urandom));
    send(5'd1, 1'b0, 9'b000000000);
    send(5'd20, 1'b0, 9'($urandom));
    wait_drain();

    // Back-to-back stream with a three-cycle downstream stall.
    saw_block = 1'b0;
    fork
      for (int i = 0; i < 8; i++)
        send(5'($urandom_range(1, 15)), 1'b0, 9'($urandom));
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_force = 1'b1;
      end
    join
    wait_drain();
    chk("stall_in_ready_low", 32'(saw_block), 32'd1);

    // Randomised traffic with random backpressure and input gaps.
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic       cdc;
      logic [4:0] tc;
      cdc = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) tc = 5'($urandom_range(0, 31));
      else tc = cdc ? 5'($urandom_range(1, 3)) : 5'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(tc, cdc, 9'($urandom));
    end
    bp_en = 1'b0;
    ready_force = 1'b1;
    wait_drain();

    // Reset with two requests in flight drops them.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send(5'd5, 1'b0, 9'($urandom));
    send(5'd9, 1'b0, 9'($urandom));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    send(5'd1, 1'b0, 9'b010_110011);
    wait_drain();
    repeat (4) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
